fifo_param: RTL

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with show-ahead output, optional full-pass
// push, almost-full flag and occupancy high-water mark.
module fifo_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned FULL_PASS = 0,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic [CNT_W-1:0] max_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             not_full_c;
    logic             push_fire_c;
    logic             pop_fire_c;

    // Advance a pointer, wrapping at DEPTH-1 (works for any DEPTH)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and status outputs from registered state; reset forces idle values
    always_comb begin
        not_full_c  = (count_q != CNT_W'(DEPTH));
        pop_valid   = rst_n & (count_q != '0);
        if (FULL_PASS != 0) begin
            push_ready = ~rst_n | not_full_c | pop_ready;
        end else begin
            push_ready = ~rst_n | not_full_c;
        end
        almost_full = rst_n & (count_q >= CNT_W'(AF_THRESH));
        pop_data    = mem_q[rd_ptr_q];
        count       = count_q;
        max_count   = max_q;
        push_fire_c = push_valid & push_ready;
        pop_fire_c  = pop_valid & pop_ready;
    end

    // Next-state for storage, pointers, occupancy and high-water mark
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_fire_c) - CNT_W'(pop_fire_c);
        max_d    = max_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            max_d    = '0;
        end else begin
            if (push_fire_c) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_fire_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (count_d > max_q) begin
                max_d = count_d;
            end
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    // Data storage is never reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
